// File: rtl/nibble_serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl_pkg
//   Shared definitions for the nibble-serial add/subtract sequencer:
//   - state_t     : FSM state encoding (IDLE / RUN / DONE)
//   - NIBBLE_W    : width of the shared adder slice (4 bits)
//   - cnt_width() : width of the nibble counter for a given nibble count
// -----------------------------------------------------------------------------
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must index NIBBLES slice passes; never narrower than one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_adder4.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl_adder4
//   The 4-bit ripple-carry adder slice shared by every nibble pass.
//   Ports:
//     x, y  in  4  slice operands
//     cin   in  1  carry into bit 0
//     sum   out 4  slice sum
//     cout  out 1  carry out of bit 3
//     ovf   out 1  signed overflow of this slice (carry into MSB ^ carry out)
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl_adder4
  import nibble_serial_add_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = c[NIBBLE_W];
  // Sign of the result is wrong exactly when the carries into and out of
  // the MSB differ; equivalent to "same operand signs, different sum sign".
  assign ovf  = c[NIBBLE_W - 1] ^ c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//   WIDTH-bit add/subtract computed one nibble per cycle (LSB first) through a
//   single 4-bit ripple slice. The inter-nibble carry is registered and the
//   partial sum is accumulated until the MSB pass, when result and flags are
//   published together. WIDTH must be a multiple of 4 and at least 8.
//
//   Ports:
//     clk        in  1      rising-edge clock
//     rst        in  1      asynchronous, active-high reset
//     start      in  1      request, sampled only in IDLE
//     sub        in  1      0: a+b, 1: a-b (two's complement), latched with start
//     a, b       in  WIDTH  operands, latched with start
//     busy       out 1      high while in RUN or DONE
//     done       out 1      registered one-cycle completion pulse
//     result     out WIDTH  sum/difference, held until the next completion
//     carry_out  out 1      carry out of the MSB (subtract: 1 = no borrow)
//     overflow   out 1      signed overflow of the WIDTH-bit operation
//
//   Timing: start sampled at edge 0, RUN passes on edges 1..NIBBLES, result
//   and flags update on edge NIBBLES, done is high after edge NIBBLES+1.
// -----------------------------------------------------------------------------
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int               NIBBLES  = WIDTH / NIBBLE_W;
  localparam int               CNT_W    = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;        // B already inverted for subtract
  logic [WIDTH-1:0]    acc_q;
  logic [WIDTH-1:0]    result_q;
  logic                carry_out_q;
  logic                overflow_q;
  logic                done_q;

  // FSM decode
  logic                load;       // latch operands, enter RUN
  logic                step;       // one slice pass this cycle
  logic                last;       // this pass handles the MSB nibble

  // Slice datapath
  logic [CNT_W+1:0]    nib_base;   // bit offset of the current nibble
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                slice_ovf;
  logic [WIDTH-1:0]    acc_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST_NIB) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;    // unused encoding recovers to IDLE
    endcase
  end

  // ---------------------------------------------------------------------------
  // Nibble mux and the shared slice
  // ---------------------------------------------------------------------------
  assign nib_base = {cnt_q, 2'b00};
  assign nib_a    = a_q[nib_base +: NIBBLE_W];
  assign nib_b    = b_q[nib_base +: NIBBLE_W];

  nibble_serial_add_ctrl_adder4 u_slice (
    .x    (nib_a),
    .y    (nib_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .ovf  (slice_ovf)
  );

  // Accumulator with the current pass's nibble merged in; on the MSB pass
  // this is the complete result.
  always_comb begin
    acc_next                        = acc_q;
    acc_next[nib_base +: NIBBLE_W] = slice_sum;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand and accumulator registers are reset along with the
  // control state, so an aborted operation leaves nothing behind that could
  // leak into a later result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // done follows the DONE state by one cycle, giving a registered pulse.
      done_q <= (state_q == DONE);

      if (load) begin
        a_q     <= a;
        b_q     <= b ^ {WIDTH{sub}};
        carry_q <= sub;                 // +1 completes the two's complement
        cnt_q   <= '0;
      end

      if (step) begin
        acc_q   <= acc_next;
        carry_q <= slice_cout;
        // Leave the counter at zero after the MSB pass instead of wrapping.
        cnt_q   <= last ? '0 : cnt_q + CNT_W'(1);
      end

      // Overflow comes only from the MSB slice; lower-slice overflow is
      // meaningless for the WIDTH-bit operation.
      if (last) begin
        result_q    <= acc_next;
        carry_out_q <= slice_cout;
        overflow_q  <= slice_ovf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
//   Directed and randomized checks of the nibble-serial add/subtract sequencer
//   against a whole-word arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int compared   = 0;
  int mismatched = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word arithmetic on widened integers.
  // Returns {carry_out, overflow, result}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic s);
    longint ux  = longint'(x);
    longint uy  = longint'(y);
    longint sx  = longint'($signed(x));
    longint sy  = longint'($signed(y));
    longint lim = longint'(1) << (WIDTH - 1);
    longint ur;
    longint sr;
    logic   c;
    logic   v;
    if (s) begin
      ur = ux - uy;
      sr = sx - sy;
      c  = (ux >= uy);               // no borrow
    end else begin
      ur = ux + uy;
      sr = sx + sy;
      c  = ((ur >> WIDTH) != 0);
    end
    v = (sr >= lim) || (sr < -lim);
    return {c, v, ur[WIDTH-1:0]};
  endfunction

  // One operation from IDLE. Operands are scrambled every cycle after the
  // start edge; poke >= 0 raises start again in that post-start cycle.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic s,
                        input int poke);
    logic [WIDTH+1:0] exp;
    logic [WIDTH-1:0] prev_res;
    int               lat;
    int               busy_cycles;
    exp      = model(x, y, s);
    prev_res = result;
    a = x; b = y; sub = s; start = 1'b1;
    tick();                                  // edge 0
    start       = 1'b0;
    lat         = 0;
    busy_cycles = int'(busy);
    while (!done && lat < 3 * NIBBLES + 10) begin
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      sub   = 1'($urandom);
      start = (lat == poke);
      tick();
      lat++;
      busy_cycles += int'(busy);
      if (lat == 2) check({tag, " result held mid-run"}, result, prev_res);
    end
    start = 1'b0;
    check({tag, " done latency"}, lat, NIBBLES + 1);
    check({tag, " busy cycles"}, busy_cycles, NIBBLES + 1);
    check({tag, " result"}, result, exp[WIDTH-1:0]);
    check({tag, " overflow"}, overflow, exp[WIDTH]);
    check({tag, " carry_out"}, carry_out, exp[WIDTH+1]);
    tick();
    check({tag, " done one cycle"}, done, 1'b0);
    check({tag, " idle after"}, busy, 1'b0);
  endtask

  initial begin : stimulus
    logic [WIDTH+1:0] exp;
    int               cyc;
    int               ndone;
    int               last_t;
    logic             prev_done;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, '0);
    check("reset carry_out", carry_out, 1'b0);
    check("reset overflow", overflow, 1'b0);
    #22 rst = 1'b0;
    tick();

    // Directed vectors
    run_op("add basic",     16'h1234, 16'h0FFF, 1'b0, -1);
    run_op("add wrap",      16'hFFFF, 16'h0001, 1'b0, -1);
    run_op("add ovf",       16'h7FFF, 16'h0001, 1'b0, -1);
    run_op("sub borrow",    16'h0005, 16'h0007, 1'b1, -1);
    run_op("sub ovf",       16'h8000, 16'h0001, 1'b1, -1);
    run_op("sub zero",      16'h0000, 16'h0000, 1'b1, -1);
    run_op("add neg ovf",   16'h8000, 16'h8000, 1'b0, -1);

    // Start re-pulsed in RUN cycle 2 must be ignored
    run_op("start in run",  16'h2468, 16'h1357, 1'b0, 1);
    repeat (NIBBLES + 2) tick();
    check("start in run no requeue", busy, 1'b0);
    check("start in run no done", done, 1'b0);

    // Asynchronous reset during RUN cycle 3
    a = 16'h0F0F; b = 16'h0101; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort result", result, '0);
    check("abort carry_out", carry_out, 1'b0);
    check("abort overflow", overflow, 1'b0);
    check("abort done", done, 1'b0);
    #2 rst = 1'b0;
    tick();
    check("abort stays idle", busy, 1'b0);
    run_op("after abort",   16'h00F0, 16'h0010, 1'b0, -1);

    // Start held high: back-to-back operations
    exp = model(16'hABCD, 16'h1111, 1'b1);
    a = 16'hABCD; b = 16'h1111; sub = 1'b1; start = 1'b1;
    cyc = -1; ndone = 0; last_t = 0; prev_done = 1'b0;
    while (ndone < 3 && cyc < 100) begin
      tick();
      cyc++;
      check("b2b no double done", prev_done & done, 1'b0);
      if (done) begin
        check("b2b result", result, exp[WIDTH-1:0]);
        check("b2b flags", {carry_out, overflow}, exp[WIDTH+1:WIDTH]);
        check("b2b spacing", cyc - last_t, (ndone == 0) ? NIBBLES + 1 : NIBBLES + 2);
        last_t = cyc;
        ndone++;
        if (ndone == 3) start = 1'b0;
      end
      prev_done = done;
    end
    check("b2b completions", ndone, 3);
    start = 1'b0;
    repeat (NIBBLES + 3) tick();
    check("b2b idle after", busy, 1'b0);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      run_op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
